// File: rtl/booth_mul_rad4_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, valid/ready on both sides.
// Optional running accumulator enabled by defining BOOTH_MAC_ACCUM_EN.
module booth_mul_rad4_seq #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH+8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
`ifdef BOOTH_MAC_ACCUM_EN
   ,
   input  logic               acc_clr,
   output logic [ACC_W-1:0]   acc_out
`endif
);

   // state  | meaning
   // S_IDLE | waiting for operands, in_ready=1
   // S_RUN  | retiring one Booth digit per cycle, then loading product
   // S_DONE | product presented, waiting for out_ready

   localparam int N  = WIDTH/2 + 1;
   localparam int PW = 2*WIDTH;
   localparam int BW = WIDTH + 3;
   localparam int CW = $clog2(N+1);
   localparam logic [CW-1:0] LAST = CW'(N);

   if ((WIDTH % 2) != 0 || WIDTH < 4 || ACC_W < 2*WIDTH) begin : g_bad_param
      $error("booth_mul_rad4_seq: WIDTH must be even and >= 4, ACC_W >= 2*WIDTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [PW-1:0]   r_product;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_psum;
   logic [PW-1:0]   r_m;
   logic [BW-1:0]   r_bext;
   logic [PW-1:0]   w_m2;
   logic [PW-1:0]   w_digit;

   // Guard bits above 2*WIDTH never reach product, so the partial sum and the
   // shifted multiplicand are kept modulo 2^(2*WIDTH); the low bits are exact.
   always_comb begin
      w_m2    = r_m << 1;
      w_digit = '0;
      case (r_bext[2:0])
         3'b001, 3'b010: w_digit = r_m;
         3'b011:         w_digit = w_m2;
         3'b100:         w_digit = -w_m2;
         3'b101, 3'b110: w_digit = -r_m;
         default:        w_digit = '0;
      endcase
   end

`ifdef BOOTH_MAC_ACCUM_EN
   logic             r_acc_clr;
   logic             r_signed;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_prod_ext;

   always_comb begin
      w_prod_ext = r_signed ? {{(ACC_W-PW){r_product[PW-1]}}, r_product}
                            : {{(ACC_W-PW){1'b0}}, r_product};
   end

   assign acc_out = r_acc;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_product   <= '0;
         r_cnt       <= '0;
         r_psum      <= '0;
         r_m         <= '0;
         r_bext      <= '0;
`ifdef BOOTH_MAC_ACCUM_EN
         r_acc_clr   <= 1'b0;
         r_signed    <= 1'b0;
         r_acc       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_m        <= is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
                  r_bext     <= is_signed ? {{2{b[WIDTH-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
                  r_psum     <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
`ifdef BOOTH_MAC_ACCUM_EN
                  r_acc_clr  <= acc_clr;
                  r_signed   <= is_signed;
`endif
               end
            end
            S_RUN: begin
               if (r_cnt == LAST) begin
                  r_product   <= r_psum;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_psum <= r_psum + w_digit;
                  r_m    <= r_m << 2;
                  r_bext <= r_bext >> 2;
                  r_cnt  <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
`ifdef BOOTH_MAC_ACCUM_EN
                  r_acc       <= (r_acc_clr ? '0 : r_acc) + w_prod_ext;
`endif
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign product   = r_product;

endmodule

// File: tb/tb_booth_mul_rad4_seq.sv
// Directed-vector bench for booth_mul_rad4_seq (WIDTH=8), with accumulator
// checks when BOOTH_MAC_ACCUM_EN is defined.
module tb_booth_mul_rad4_seq;

   localparam int WIDTH = 8;
   localparam int ACC_W = 2*WIDTH+8;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic               is_signed;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
`ifdef BOOTH_MAC_ACCUM_EN
   logic               acc_clr;
   logic [ACC_W-1:0]   acc_out;
`else
   logic               acc_clr;
`endif

   int n_vec = 0;
   int n_err = 0;

   booth_mul_rad4_seq #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
`ifdef BOOTH_MAC_ACCUM_EN
      ,
      .acc_clr   (acc_clr),
      .acc_out   (acc_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic sgn, input logic [7:0] ia,
                         input logic [7:0] ib, input logic clr,
                         input logic [15:0] exp, input int hold);
      int t;
      int lat;
      logic [15:0] held;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_in_ready_idle"}, in_ready, 1);
      in_valid  = 1'b1;
      is_signed = sgn;
      a         = ia;
      b         = ib;
      acc_clr   = clr;
      @(posedge clk);
      #1;
      // scramble operands after the accept; they must be ignored
      in_valid  = 1'b0;
      a         = ~ia;
      b         = 8'h5A;
      is_signed = ~sgn;
      acc_clr   = ~clr;
      held      = product;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 3) chk({tag, "_prod_held_in_run"}, product, held);
      end
      chk({tag, "_latency"}, lat, 6);
      chk({tag, "_product"}, product, exp);
      chk({tag, "_in_ready_done"}, in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk({tag, "_bp_valid"}, out_valid, 1);
         chk({tag, "_bp_product"}, product, exp);
         chk({tag, "_bp_in_ready"}, in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_valid_after_hs"}, out_valid, 0);
      chk({tag, "_in_ready_after_hs"}, in_ready, 1);
      chk({tag, "_product_retained"}, product, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      is_signed = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      acc_clr   = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_product", product, 16'h0000);
`ifdef BOOTH_MAC_ACCUM_EN
      chk("rst_acc_out", acc_out, 32'h0);
`endif
      #10;
      rst_n = 1'b1;

      run_op("s_m128_m128", 1'b1, 8'h80, 8'h80, 1'b0, 16'h4000, 0);
      run_op("s_127_m1",    1'b1, 8'h7F, 8'hFF, 1'b0, 16'hFF81, 0);
      run_op("s_m3_5_bp",   1'b1, 8'hFD, 8'h05, 1'b0, 16'hFFF1, 5);
      run_op("u_255_255",   1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
      run_op("u_200_3",     1'b0, 8'hC8, 8'h03, 1'b0, 16'h0258, 0);
      run_op("u_aa_55",     1'b0, 8'hAA, 8'h55, 1'b0, 16'h3872, 0);
      run_op("s_m1_m1",     1'b1, 8'hFF, 8'hFF, 1'b0, 16'h0001, 0);
      run_op("s_m128_127",  1'b1, 8'h80, 8'h7F, 1'b0, 16'hC080, 0);

      // abort an operation with reset during its second RUN cycle
      @(negedge clk);
      in_valid  = 1'b1;
      is_signed = 1'b0;
      a         = 8'd100;
      b         = 8'd100;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_product", product, 16'h0000);
      chk("abort_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         chk("abort_no_output", out_valid, 0);
      end
      chk("abort_in_ready_rel", in_ready, 1);
      run_op("u_7_9", 1'b0, 8'd7, 8'd9, 1'b0, 16'd63, 0);

      run_op("acc_3_4", 1'b0, 8'd3, 8'd4, 1'b1, 16'd12, 0);
`ifdef BOOTH_MAC_ACCUM_EN
      chk("acc_seq0", acc_out, 32'd12);
`endif
      run_op("acc_5_6", 1'b0, 8'd5, 8'd6, 1'b0, 16'd30, 0);
`ifdef BOOTH_MAC_ACCUM_EN
      chk("acc_seq1", acc_out, 32'd42);
`endif
      run_op("acc_m2_5", 1'b1, 8'hFE, 8'd5, 1'b0, 16'hFFF6, 0);
`ifdef BOOTH_MAC_ACCUM_EN
      chk("acc_seq2", acc_out, 32'd32);
      repeat (3) @(posedge clk);
      #1;
      chk("acc_hold", acc_out, 32'd32);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
